fetcher: RTL and testbench

//  Instruction unpacker between the bus-fetch FSM in top and decode. Takes each 64-bit bus beat
//  (two RV 32-bit instructions, low word first), buffers them in a small FIFO, and presents one

---
 rtl/fetcher_pkg.sv | 74 +++++++
 rtl/fetcher_fifo.sv | 85 ++++++++
 rtl/fetcher.sv | 125 ++++++++++++
 tb/tb_fetcher.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetcher_pkg.sv
// Shared definitions for the instruction fetcher: RV opcode constants, the
// instruction format type, the FIFO entry layout and the decode helpers
// (format lookup, legality check, immediate generation).
package fetcher_pkg;

    // Base opcodes recognised by the decoder.
    localparam logic [6:0] OP_LOAD     = 7'h03;
    localparam logic [6:0] OP_MISC_MEM = 7'h0F;
    localparam logic [6:0] OP_IMM      = 7'h13;
    localparam logic [6:0] OP_AUIPC    = 7'h17;
    localparam logic [6:0] OP_IMM_32   = 7'h1B;
    localparam logic [6:0] OP_STORE    = 7'h23;
    localparam logic [6:0] OP_OP       = 7'h33;
    localparam logic [6:0] OP_LUI      = 7'h37;
    localparam logic [6:0] OP_OP_32    = 7'h3B;
    localparam logic [6:0] OP_BRANCH   = 7'h63;
    localparam logic [6:0] OP_JALR     = 7'h67;
    localparam logic [6:0] OP_JAL      = 7'h6F;
    localparam logic [6:0] OP_SYSTEM   = 7'h73;

    localparam int WORD_W  = 32;
    localparam int OFF_W   = 9;
    localparam int ENTRY_W = WORD_W + OFF_W;

    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} instr_fmt_e;

    // One FIFO slot: the instruction word and its byte offset in the line.
    typedef struct packed {
        logic [OFF_W-1:0]  off;
        logic [WORD_W-1:0] word;
    } fifo_entry_t;

    // Immediate format implied by the opcode; R covers everything without an immediate.
    function automatic instr_fmt_e fmt_of(input logic [6:0] op);
        instr_fmt_e fmt;
        case (op)
            OP_LOAD, OP_IMM, OP_IMM_32, OP_JALR, OP_SYSTEM: fmt = FMT_I;
            OP_STORE:                                       fmt = FMT_S;
            OP_BRANCH:                                      fmt = FMT_B;
            OP_LUI, OP_AUIPC:                               fmt = FMT_U;
            OP_JAL:                                         fmt = FMT_J;
            default:                                        fmt = FMT_R;
        endcase
        return fmt;
    endfunction

    // A word is legal when it is a 32-bit encoding with a known base opcode.
    function automatic logic is_legal(input logic [31:0] instr);
        logic known;
        case (instr[6:0])
            OP_LOAD, OP_MISC_MEM, OP_IMM, OP_AUIPC, OP_IMM_32, OP_STORE, OP_OP,
            OP_LUI, OP_OP_32, OP_BRANCH, OP_JALR, OP_JAL, OP_SYSTEM: known = 1'b1;
            default:                                                 known = 1'b0;
        endcase
        return known && (instr[1:0] == 2'b11);
    endfunction

    // Immediate assembled to 32 bits per format, then sign-extended from bit 31.
    function automatic logic [63:0] imm_gen(input logic [31:0] instr);
        logic [31:0] imm32;
        case (fmt_of(instr[6:0]))
            FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                              instr[11:8], 1'b0};
            FMT_U:   imm32 = {instr[31:12], 12'b0};
            FMT_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                              instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
        return {{32{imm32[31]}}, imm32};
    endfunction

endpackage

// File: rtl/fetcher_fifo.sv
// Dual-push, single-pop FIFO. Up to two words enter per cycle (port a is
// always placed ahead of port b); one word leaves per cycle. Space is judged
// on the occupancy at the start of the cycle, so a simultaneous pop does not
// make room for that cycle's pushes. When space runs short, port b is
// refused before port a, and 'dropped' flags any refused request.
module fetcher_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 41
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_a,
    input  logic [WIDTH-1:0] data_a,
    input  logic             push_b,
    input  logic [WIDTH-1:0] data_b,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             dropped
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      level;
    logic [AW:0]      free;
    logic             acc_a;
    logic             acc_b;
    logic             do_pop;
    logic [1:0]       n_push;
    logic [AW-1:0]    wr_ptr_b;

    assign free     = DEPTH_L - level;
    assign empty    = (level == '0);
    assign do_pop   = pop && !empty;
    assign n_push   = {1'b0, acc_a} + {1'b0, acc_b};
    assign wr_ptr_b = wr_ptr + AW'(acc_a);
    assign head     = mem[rd_ptr];

    // Decide which push requests fit; port b needs a second free slot when port a also pushes.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
        acc_a   = 1'b0;
        acc_b   = 1'b0;
        dropped = 1'b0;
        if (push_a && (free != '0)) begin
            acc_a = 1'b1;
        end
        if (push_b && (free >= (push_a ? (AW+1)'(2) : (AW+1)'(1)))) begin
            acc_b = 1'b1;
        end
        if ((push_a && !acc_a) || (push_b && !acc_b)) begin
            dropped = 1'b1;
        end
    end

    // Storage array: written at the write pointer, port a first then port b.
    // NOTE: the data array is not reset; the pointers and level alone define which slots are valid.
    always_ff @(posedge clk) begin
        if (acc_a) begin
            mem[wr_ptr] <= data_a;
        end
        if (acc_b) begin
            mem[wr_ptr_b] <= data_b;
        end
    end

    // Pointers and occupancy: level = old + pushes - pops, pointers wrap modulo DEPTH.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(n_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            level  <= level + (AW+1)'(n_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/fetcher.sv
// Instruction unpacker: splits each 64-bit bus beat into two 32-bit
// instructions (low word first), skips all-zero padding words, queues them
// with their byte offsets and presents the head with decoded fields.
// Tracks the end of the fetch stream and raises a sticky done once drained.
// Optional build macro FETCHER_TRACE_EN adds simulation-only pop tracing.
module fetcher
    import fetcher_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_en,
    input  logic [63:0] data,
    input  logic [5:0]  count,
    input  logic        end_of_cycle,
    input  logic        instr_ready,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [8:0]  instr_off,
    output logic [6:0]  opcode,
    output logic [4:0]  rd,
    output logic [2:0]  funct3,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [6:0]  funct7,
    output logic [63:0] imm,
    output logic        illegal,
    output logic        overflow,
    output logic        done
);

    logic        ended;
    logic        take_beat;
    logic        push_lo;
    logic        push_hi;
    logic        pop;
    logic        fifo_empty;
    logic        dropped;
    fifo_entry_t lo_entry;
    fifo_entry_t hi_entry;
    fifo_entry_t head;

    // Beats are accepted until the end marker has been registered; zero words are padding.
    assign take_beat = fetch_en && !ended;
    assign push_lo   = take_beat && (data[31:0]  != 32'h0);
    assign push_hi   = take_beat && (data[63:32] != 32'h0);
    assign lo_entry  = '{off: {count, 3'b000}, word: data[31:0]};
    assign hi_entry  = '{off: {count, 3'b100}, word: data[63:32]};

    fetcher_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_a  (push_lo),
        .data_a  (lo_entry),
        .push_b  (push_hi),
        .data_b  (hi_entry),
        .pop     (pop),
        .head    (head),
        .empty   (fifo_empty),
        .dropped (dropped)
    );

    // Head presentation: zeroed while empty so idle outputs are all 0.
    assign instr_valid = !fifo_empty;
    assign pop         = instr_valid && instr_ready;
    assign instr       = instr_valid ? head.word : '0;
    assign instr_off   = instr_valid ? head.off  : '0;

    // Field extraction is pure slicing of the presented word.
    assign opcode  = instr[6:0];
    assign rd      = instr[11:7];
    assign funct3  = instr[14:12];
    assign rs1     = instr[19:15];
    assign rs2     = instr[24:20];
    assign funct7  = instr[31:25];
    assign imm     = imm_gen(instr);
    assign illegal = instr_valid && !is_legal(instr);

    // Sticky status: end seen, word dropped on a full FIFO, and drained after end.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ended    <= 1'b0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            if (end_of_cycle) begin
                ended <= 1'b1;
            end
            if (dropped) begin
                overflow <= 1'b1;
            end
            if (ended && fifo_empty) begin
                done <= 1'b1;
            end
        end
    end

`ifdef FETCHER_TRACE_EN
    logic [31:0] pop_total;
    logic        done_rise;

    assign done_rise = ended && fifo_empty && !done;

    // Simulation trace: log each popped instruction and the total when done rises.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pop_total <= '0;
        end else begin
            if (pop) begin
                pop_total <= pop_total + 32'd1;
                $display("%0h: %08h", instr_off, instr);
            end
            if (done_rise) begin
                $display("fetcher: %0d instructions popped", pop_total);
            end
        end
    end
`else
`endif

endmodule

// File: tb/tb_fetcher.sv
// Directed testbench for fetcher: reset state, beat unpacking and offsets,
// padding skip, immediate formats, illegal detection, full-FIFO drops,
// mid-stream reset and end/done handling. Expected values are hand-computed.
module tb_fetcher;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_en;
    logic [63:0] data;
    logic [5:0]  count;
    logic        end_of_cycle;
    logic        instr_ready;
    logic        instr_valid;
    logic [31:0] instr;
    logic [8:0]  instr_off;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [63:0] imm;
    logic        illegal;
    logic        overflow;
    logic        done;

    int n_total = 0;
    int n_bad   = 0;

    logic [31:0] exp_w [8];
    logic [8:0]  exp_o [8];

    always #5 clk = ~clk;

    fetcher #(.FIFO_DEPTH(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .fetch_en     (fetch_en),
        .data         (data),
        .count        (count),
        .end_of_cycle (end_of_cycle),
        .instr_ready  (instr_ready),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .instr_off    (instr_off),
        .opcode       (opcode),
        .rd           (rd),
        .funct3       (funct3),
        .rs1          (rs1),
        .rs2          (rs2),
        .funct7       (funct7),
        .imm          (imm),
        .illegal      (illegal),
        .overflow     (overflow),
        .done         (done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [63:0] d, input logic [5:0] c);
        fetch_en = 1'b1;
        data     = d;
        count    = c;
        step();
        fetch_en = 1'b0;
        data     = '0;
        count    = '0;
    endtask

    // addi x0, x0, i -- distinct non-zero legal words.
    function automatic logic [31:0] w(input int i);
        return 32'h0000_0013 | (32'(i) << 20);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset        = 1'b0;
        fetch_en     = 1'b0;
        data         = '0;
        count        = '0;
        end_of_cycle = 1'b0;
        instr_ready  = 1'b0;

        // Reset held low for two cycles.
        step();
        step();
        check("rst_valid",    instr_valid, 0);
        check("rst_done",     done,        0);
        check("rst_overflow", overflow,    0);
        check("rst_instr",    instr,       0);
        reset = 1'b1;

        // Basic beat: two instructions, offsets from count=1.
        instr_ready = 1'b1;
        beat(64'h00000013_00a00093, 6'd1);
        check("b0_valid",  instr_valid, 1);
        check("b0_instr",  instr,       32'h00a00093);
        check("b0_off",    instr_off,   9'h008);
        check("b0_opcode", opcode,      7'h13);
        check("b0_rd",     rd,          5'd1);
        check("b0_imm",    imm,         64'd10);
        check("b0_ill",    illegal,     0);
        step();
        check("b1_instr",  instr,       32'h00000013);
        check("b1_off",    instr_off,   9'h00C);
        step();
        check("b_empty",   instr_valid, 0);

        // Padding high word is skipped.
        beat(64'h00000000_fe010113, 6'd2);
        check("pad_instr", instr,     32'hfe010113);
        check("pad_off",   instr_off, 9'h010);
        check("pad_rd",    rd,        5'd2);
        check("pad_rs1",   rs1,       5'd2);
        check("pad_imm",   imm,       64'hFFFF_FFFF_FFFF_FFE0);
        step();
        check("pad_empty", instr_valid, 0);

        // Immediate formats: lui, jal, sw, beq.
        fetch_en = 1'b1;
        data     = 64'hFFDFF0EF_123450B7;
        count    = 6'd6;
        step();
        check("u_instr", instr, 32'h123450B7);
        check("u_imm",   imm,   64'h0000_0000_1234_5000);
        data  = 64'hFE000CE3_0020A423;
        count = 6'd7;
        step();
        fetch_en = 1'b0;
        data     = '0;
        count    = '0;
        check("j_instr",  instr,     32'hFFDFF0EF);
        check("j_off",    instr_off, 9'h034);
        check("j_imm",    imm,       64'hFFFF_FFFF_FFFF_FFFC);
        step();
        check("s_imm",    imm,       64'd8);
        check("s_funct3", funct3,    3'd2);
        check("s_rs1",    rs1,       5'd1);
        check("s_rs2",    rs2,       5'd2);
        step();
        check("b_imm",    imm,       64'hFFFF_FFFF_FFFF_FFF8);
        check("b_funct7", funct7,    7'h7F);
        check("b_off",    instr_off, 9'h03C);
        step();
        check("fmt_empty", instr_valid, 0);

        // Illegal encodings: low bits not 11, then unknown opcode.
        beat(64'h0000007F_00000001, 6'd0);
        check("ill0_flag",   illegal, 1);
        check("ill0_opcode", opcode,  7'h01);
        step();
        check("ill1_instr",  instr,   32'h0000007F);
        check("ill1_flag",   illegal, 1);
        step();
        check("ill_idle",    illegal, 0);

        // Full FIFO: five pairs into eight slots, last beat dropped.
        instr_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            beat({w(2*k+2), w(2*k+1)}, 6'(k));
        end
        check("full_ovf_before", overflow, 0);
        beat({w(10), w(9)}, 6'd4);
        check("full_ovf_after",  overflow, 1);
        instr_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("full_word", instr,     w(i+1));
            check("full_off",  instr_off, 9'(4*i));
            step();
        end
        check("full_drained", instr_valid, 0);
        check("full_ovf_held", overflow,   1);

        // Partial fit after reset: seven held, next pair keeps low word, drops high.
        reset = 1'b0;
        step();
        reset = 1'b1;
        check("part_ovf_clr", overflow, 0);
        instr_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            beat({w(12+2*k), w(11+2*k)}, 6'(k));
        end
        beat({32'h0, w(17)}, 6'd3);
        check("part_ovf_before", overflow, 0);
        beat({w(19), w(18)}, 6'd4);
        check("part_ovf_after",  overflow, 1);
        for (int i = 0; i < 6; i++) begin
            exp_w[i] = w(11+i);
            exp_o[i] = 9'(4*i);
        end
        exp_w[6] = w(17);
        exp_o[6] = 9'h018;
        exp_w[7] = w(18);
        exp_o[7] = 9'h020;
        instr_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("part_word", instr,     exp_w[i]);
            check("part_off",  instr_off, exp_o[i]);
            step();
        end
        check("part_drained", instr_valid, 0);

        // Reset mid-stream discards queued words and sticky flags.
        instr_ready = 1'b0;
        beat({w(21), w(20)}, 6'd0);
        check("mid_valid_before", instr_valid, 1);
        reset = 1'b0;
        step();
        check("mid_valid", instr_valid, 0);
        check("mid_ovf",   overflow,    0);
        check("mid_instr", instr,       0);
        reset = 1'b1;

        // End of stream with two queued, then drain and done.
        beat({w(31), w(30)}, 6'd5);
        end_of_cycle = 1'b1;
        step();
        end_of_cycle = 1'b0;
        check("end_done0", done,        0);
        check("end_valid", instr_valid, 1);
        instr_ready = 1'b1;
        step();
        check("end_second", instr,     w(31));
        check("end_off",    instr_off, 9'h02C);
        step();
        check("end_empty",  instr_valid, 0);
        check("end_done1",  done,        0);
        step();
        check("end_done2",  done,        1);
        beat({w(33), w(32)}, 6'd6);
        check("end_ignored", instr_valid, 0);
        check("end_held",    done,        1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
